// File: rtl/trap_ctrl.sv
// Trap sequencer: prioritises commit-point exceptions, mret and the timer IRQ, drains memory, strobes the CSR unit.
// Optional TRAP_CTRL_PERF_EN adds trap_count/irq_count event counters.
module trap_ctrl #(
  parameter int         MXLEN       = 64,
  parameter logic [4:0] MRET_CAUSE  = 5'h1F,
  parameter logic [4:0] TIMER_CAUSE = 5'h17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [MXLEN-1:0] ex_pc,
  input  logic             ex_illegal,
  input  logic             ex_ebreak,
  input  logic             ex_ecall,
  input  logic             ex_mret,
  input  logic             mstatus_mie,
  input  logic             mie_mtie,
  input  logic             timer_irq,
  input  logic             mem_busy,
  output logic             exception_flag,
  output logic [4:0]       exception_cause,
  output logic [MXLEN-1:0] epc,
  output logic             stall,
  output logic             flush
`ifdef TRAP_CTRL_PERF_EN
  ,
  output logic [MXLEN-1:0] trap_count,
  output logic [MXLEN-1:0] irq_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FIRE, S_HOLD} state_t;

  state_t           r_state;
  logic [4:0]       r_cause;
  logic [MXLEN-1:0] r_epc;
  logic             r_flag, r_stall, r_flush;
  logic [4:0]       r_cause_o;
  logic [MXLEN-1:0] r_epc_o;

  logic       w_irq_take;
  logic       w_event;
  logic [4:0] w_cause;

  assign w_irq_take = timer_irq & mie_mtie & mstatus_mie;
  assign w_event    = ex_valid & (w_irq_take | ex_illegal | ex_ebreak | ex_ecall | ex_mret);

  always_comb begin
    w_cause = MRET_CAUSE;
    if (w_irq_take)      w_cause = TIMER_CAUSE;
    else if (ex_illegal) w_cause = 5'd2;
    else if (ex_ebreak)  w_cause = 5'd3;
    else if (ex_ecall)   w_cause = 5'd11;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cause   <= '0;
      r_epc     <= '0;
      r_flag    <= 1'b0;
      r_stall   <= 1'b0;
      r_flush   <= 1'b0;
      r_cause_o <= '0;
      r_epc_o   <= '0;
    end else begin
      r_flag    <= 1'b0;
      r_cause_o <= '0;
      r_epc_o   <= '0;
      case (r_state)
        S_IDLE: begin
          r_stall <= 1'b0;
          r_flush <= 1'b0;
          if (w_event) begin
            r_cause <= w_cause;
            r_epc   <= ex_pc;
            r_stall <= 1'b1;
            if (mem_busy) begin
              r_state <= S_DRAIN;
            end else begin
              r_state   <= S_FIRE;
              r_flag    <= 1'b1;
              r_flush   <= 1'b1;
              r_cause_o <= w_cause;
              r_epc_o   <= ex_pc;
            end
          end
        end
        S_DRAIN: begin
          r_stall <= 1'b1;
          if (!mem_busy) begin
            r_state   <= S_FIRE;
            r_flag    <= 1'b1;
            r_flush   <= 1'b1;
            r_cause_o <= r_cause;
            r_epc_o   <= r_epc;
          end
        end
        S_FIRE: begin
          r_state <= S_HOLD;
          r_stall <= 1'b1;
          r_flush <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_stall <= 1'b0;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  assign exception_flag  = r_flag;
  assign exception_cause = r_cause_o;
  assign epc             = r_epc_o;
  assign flush           = r_flush;
  // Stall must cover the detection cycle itself, before the FSM registers anything.
  assign stall           = r_stall | ((r_state == S_IDLE) & w_event);

`ifdef TRAP_CTRL_PERF_EN
  logic [MXLEN-1:0] r_trap_cnt, r_irq_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_trap_cnt <= '0;
      r_irq_cnt  <= '0;
    end else if (r_state == S_FIRE) begin
      if (r_cause != MRET_CAUSE) r_trap_cnt <= r_trap_cnt + 1'b1;
      if (r_cause[4])            r_irq_cnt  <= r_irq_cnt + 1'b1;
    end
  end

  assign trap_count = r_trap_cnt;
  assign irq_count  = r_irq_cnt;
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus pushes expected strobes, a negedge monitor pops and checks them.
module tb_trap_ctrl;
  localparam int MXLEN = 64;

  logic             clk = 1'b0, rst = 1'b1;
  logic             ex_valid, ex_illegal, ex_ebreak, ex_ecall, ex_mret;
  logic [MXLEN-1:0] ex_pc;
  logic             mstatus_mie, mie_mtie, timer_irq, mem_busy;
  logic             exception_flag, stall, flush;
  logic [4:0]       exception_cause;
  logic [MXLEN-1:0] epc;
`ifdef TRAP_CTRL_PERF_EN
  logic [MXLEN-1:0] trap_count, irq_count;
`endif

  trap_ctrl #(.MXLEN(MXLEN)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_illegal(ex_illegal), .ex_ebreak(ex_ebreak), .ex_ecall(ex_ecall), .ex_mret(ex_mret),
    .mstatus_mie(mstatus_mie), .mie_mtie(mie_mtie), .timer_irq(timer_irq), .mem_busy(mem_busy),
    .exception_flag(exception_flag), .exception_cause(exception_cause), .epc(epc),
    .stall(stall), .flush(flush)
`ifdef TRAP_CTRL_PERF_EN
    , .trap_count(trap_count), .irq_count(irq_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]       cause;
    logic [MXLEN-1:0] pc;
    int               at;
  } exp_t;
  exp_t q[$];

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest expectation, including the cycle it lands in.
  logic prev_flag = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (exception_flag === 1'b1) begin
      chk("flag_not_consecutive", {63'd0, prev_flag}, 64'd0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got cause %h epc %h expected none (cycle %0d)",
                 exception_cause, epc, cyc);
      end else begin
        e = q.pop_front();
        chk("strobe_cause", {59'd0, exception_cause}, {59'd0, e.cause});
        chk("strobe_epc", epc, e.pc);
        chk("strobe_cycle", 64'(cyc), 64'(e.at));
      end
    end
    prev_flag = (exception_flag === 1'b1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  task automatic clr();
    ex_valid = 0; ex_illegal = 0; ex_ebreak = 0; ex_ecall = 0; ex_mret = 0;
    ex_pc = '0; timer_irq = 0; mem_busy = 0;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_stall"}, {63'd0, stall}, 64'd0);
    chk({name, "_flush"}, {63'd0, flush}, 64'd0);
    chk({name, "_flag"},  {63'd0, exception_flag}, 64'd0);
    chk({name, "_cause"}, {59'd0, exception_cause}, 64'd0);
    chk({name, "_epc"},   epc, 64'd0);
  endtask

  initial begin : stim
    int n;
    clr();
    mstatus_mie = 0; mie_mtie = 0;
    settle(2);
    @(negedge clk);
    chk_idle("reset");
    step();
    rst = 0;

    // ecall, no memory traffic: strobe at N+1, flush N+1..N+2, idle N+3
    step();
    ex_valid = 1; ex_ecall = 1; ex_pc = 64'h8000_0010; n = cyc;
    q.push_back('{5'd11, 64'h8000_0010, n + 1});
    @(negedge clk);
    chk("ecall_stall_N", {63'd0, stall}, 64'd1);
    chk("ecall_flush_N", {63'd0, flush}, 64'd0);
    step(); clr();
    @(negedge clk);
    chk("ecall_flush_N1", {63'd0, flush}, 64'd1);
    chk("ecall_stall_N1", {63'd0, stall}, 64'd1);
    step();
    @(negedge clk);
    chk("ecall_flush_N2", {63'd0, flush}, 64'd1);
    chk("ecall_stall_N2", {63'd0, stall}, 64'd1);
    chk("ecall_cause_N2", {59'd0, exception_cause}, 64'd0);
    step();
    @(negedge clk);
    chk_idle("ecall_N3");

    // all sources at once: timer wins, then illegal when MIE is off
    step();
    ex_valid = 1; ex_illegal = 1; ex_ecall = 1; ex_mret = 1; ex_pc = 64'h8000_0020;
    timer_irq = 1; mie_mtie = 1; mstatus_mie = 1; n = cyc;
    q.push_back('{5'h17, 64'h8000_0020, n + 1});
    step(); clr();
    settle(3);
    mstatus_mie = 0;
    step();
    ex_valid = 1; ex_illegal = 1; ex_ecall = 1; ex_mret = 1; ex_pc = 64'h8000_0024;
    timer_irq = 1; n = cyc;
    q.push_back('{5'd2, 64'h8000_0024, n + 1});
    step(); clr();
    settle(3);

    // ebreak behind 3 busy cycles; IRQ/illegal noise during drain must not change it
    step();
    mstatus_mie = 1; mie_mtie = 1;
    ex_valid = 1; ex_ebreak = 1; ex_pc = 64'h8000_0030; mem_busy = 1; n = cyc;
    q.push_back('{5'd3, 64'h8000_0030, n + 4});
    @(negedge clk);
    chk("drain_stall_N", {63'd0, stall}, 64'd1);
    for (int i = 1; i <= 2; i++) begin
      step();
      ex_ebreak = 0; ex_illegal = 1; ex_pc = 64'h8000_0FF0; timer_irq = (i == 1);
      @(negedge clk);
      chk("drain_stall", {63'd0, stall}, 64'd1);
      chk("drain_flush", {63'd0, flush}, 64'd0);
    end
    step(); clr();
    @(negedge clk);
    chk("drain_stall_N3", {63'd0, stall}, 64'd1);
    settle(4);

    // mret
    step();
    ex_valid = 1; ex_mret = 1; ex_pc = 64'h8000_0100; n = cyc;
    q.push_back('{5'h1F, 64'h8000_0100, n + 1});
    step(); clr();
    settle(3);
`ifdef TRAP_CTRL_PERF_EN
    chk("perf_trap_count", trap_count, 64'd4);
    chk("perf_irq_count", irq_count, 64'd1);
`endif

    // ex_valid low hides everything, including a takeable interrupt
    step();
    ex_valid = 0; ex_ecall = 1; timer_irq = 1; ex_pc = 64'h8000_0200;
    @(negedge clk);
    chk("novalid_stall", {63'd0, stall}, 64'd0);
    step(); clr();
    settle(2);

    // reset while draining: event is dropped, a later event goes through
    step();
    ex_valid = 1; ex_ecall = 1; ex_pc = 64'h8000_0040; mem_busy = 1;
    step(); clr();
    mem_busy = 1; rst = 1;
    @(negedge clk);
    chk("rstdrain_stall_pre", {63'd0, stall}, 64'd1);
    step();
    rst = 0; mem_busy = 0;
    @(negedge clk);
    chk_idle("rstdrain");
    settle(3);
`ifdef TRAP_CTRL_PERF_EN
    chk("perf_trap_after_rst", trap_count, 64'd0);
    chk("perf_irq_after_rst", irq_count, 64'd0);
`endif
    step();
    ex_valid = 1; ex_ecall = 1; ex_pc = 64'h8000_0050; n = cyc;
    q.push_back('{5'd11, 64'h8000_0050, n + 1});
    step(); clr();
    settle(3);

    // held ecall: second accepted in first IDLE cycle after HOLD, epc of first unaffected by pc change
    step();
    ex_valid = 1; ex_ecall = 1; ex_pc = 64'h8000_0060; n = cyc;
    q.push_back('{5'd11, 64'h8000_0060, n + 1});
    q.push_back('{5'd11, 64'h8000_0064, n + 4});
    step();
    ex_pc = 64'h8000_0064;
    settle(3);
    clr();
    settle(4);

    chk("all_strobes_seen", 64'(q.size()), 64'd0);
`ifdef TRAP_CTRL_PERF_EN
    chk("perf_trap_final", trap_count, 64'd3);
    chk("perf_irq_final", irq_count, 64'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap sequencer between the commit point of the pipeline and the CSR unit.
- Collects synchronous exceptions, mret and the machine timer interrupt for the instruction at the commit point, and prioritises them.
- Waits for outstanding memory traffic to drain, then issues a single-cycle exception_flag/exception_cause/epc strobe to the CSR unit.
- Flushes and stalls the pipeline around the trap so the redirect to the trap target is clean.

Parameters:
- MXLEN, 64, data/PC width
- MRET_CAUSE, 5'h1F, cause code the CSR unit decodes as mret (must match the CSR unit's MRET encoding)
- TIMER_CAUSE, 5'h17, {interrupt bit, code 7}: machine timer interrupt

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  valid instruction at commit point
- ex_pc  in  MXLEN  PC of that instruction
- ex_illegal  in  1  illegal instruction (cause 2)
- ex_ebreak  in  1  ebreak (cause 3)
- ex_ecall  in  1  ecall from M-mode (cause 11)
- ex_mret  in  1  mret at commit
- mstatus_mie  in  1  mstatus.MIE from CSR unit
- mie_mtie  in  1  timer interrupt enable
- timer_irq  in  1  level timer interrupt from CLINT
- mem_busy  in  1  outstanding load/store not yet complete
- exception_flag  out  1  one-cycle trap/mret strobe to CSR unit
- exception_cause  out  5  {interrupt, code[3:0]} or MRET_CAUSE
- epc  out  MXLEN  PC written to mepc
- stall  out  1  hold fetch/decode/execute
- flush  out  1  kill all younger in-flight instructions

Behaviour:
- Reset: state=IDLE; all outputs 0; latched cause/epc 0. Reset in any state aborts the trap; no strobe is issued.
- Event detection (IDLE only, requires ex_valid=1):
  - irq_take = timer_irq & mie_mtie & mstatus_mie.
  - Priority, highest first: irq_take (TIMER_CAUSE) > ex_illegal (5'd2) > ex_ebreak (5'd3) > ex_ecall (5'd11) > ex_mret (MRET_CAUSE).
  - Lower-priority sources in the same cycle are dropped.
  - epc latched = ex_pc for every cause. An interrupted instruction has not executed.
- State machine:
  - IDLE: if an event is detected, latch cause/epc and assert stall combinationally in the same cycle. Next state is DRAIN if mem_busy=1, else FIRE. With no event, stay in IDLE.
  - DRAIN: stall=1. Stay while mem_busy=1; go to FIRE the first cycle mem_busy=0.
  - FIRE: exception_flag=1, exception_cause/epc = latched values, flush=1, stall=1. Exactly one cycle, then HOLD.
  - HOLD: flush=1, stall=1 for one cycle, letting the CSR-computed target PC redirect fetch. Then IDLE.
- exception_cause and epc are held 0 outside FIRE.
- Latency: event at cycle N with mem_busy=0 gives exception_flag at N+1 and the IDLE return at N+3. Each cycle of mem_busy adds one cycle.
- A latched event is committed:
  - timer_irq or mstatus_mie dropping during DRAIN does not cancel it.
  - ex_* changes after latch are ignored.
- Events arriving in DRAIN/FIRE/HOLD are ignored. The pipeline re-presents the instruction after the flush.
- ex_valid=0 suppresses all detection, including a pending interrupt.
- Back-to-back: the earliest next event can be accepted in the first IDLE cycle after HOLD.
- exception_flag is never asserted for two consecutive cycles.

Optional Feature:
- TRAP_CTRL_PERF_EN
- Defined:
  - Adds output ports trap_count (MXLEN) and irq_count (MXLEN), reset to 0.
  - trap_count increments on every FIRE whose cause is not MRET_CAUSE.
  - irq_count increments on every FIRE whose cause bit 4 = 1.
  - Both wrap modulo 2^MXLEN.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- ecall: ex_valid=1, ex_ecall=1, ex_pc=0x8000_0010, mem_busy=0 at cycle N -> exception_flag=1 at N+1 only, exception_cause=5'd11, epc=0x8000_0010; flush=1 at N+1 and N+2; back in IDLE at N+3.
- Simultaneous: ex_illegal=1, ex_ecall=1, ex_mret=1, timer_irq=1, mie_mtie=1, mstatus_mie=1 -> cause=5'h17. Repeat with mstatus_mie=0 -> cause=5'd2.
- Drain: ex_ebreak=1 with mem_busy=1 for 3 cycles from N -> stall=1 from N, exception_flag=1 at N+4 with cause=5'd3. timer_irq toggling during the drain has no effect on that cause.
- mret: ex_mret=1, ex_pc=0x8000_0100 -> single strobe with cause=5'h1F; no other cause is generated.
- Reset mid-DRAIN: rst=1 while in DRAIN -> next cycle all outputs 0 and no exception_flag ever issued for that event. An event presented after rst=0 is taken normally.
- With TRAP_CTRL_PERF_EN: ecall, timer interrupt, mret sequence -> trap_count=2, irq_count=1.
